// File: rtl/if_id_buffer.sv
// if_id_buffer: FWFT {pc, inst} buffer between fetch and decode with flush; optional perf counters via IF_ID_PERF_CNT_EN
module if_id_buffer #(
    parameter int DEPTH = 2,
    parameter int XLEN  = 32
) (
    input  logic                     sclk_i,
    input  logic                     srst_i,
    input  logic                     flush_i,
    input  logic                     if_valid_i,
    output logic                     if_ready_o,
    input  logic [XLEN-1:0]          if_pc_i,
    input  logic [XLEN-1:0]          if_inst_i,
    output logic                     id_valid_o,
    input  logic                     id_ready_i,
    output logic [XLEN-1:0]          id_pc_o,
    output logic [XLEN-1:0]          id_inst_o,
    output logic                     id_illegal_o,
    output logic [$clog2(DEPTH):0]   count_o
`ifdef IF_ID_PERF_CNT_EN
    ,
    output logic [31:0]              stall_cnt_o,
    output logic [31:0]              flush_cnt_o
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   count;
    logic [XLEN-1:0] pc_mem   [DEPTH];
    logic [XLEN-1:0] inst_mem [DEPTH];
    logic            push, pop;

    // Handshake qualification; ready depends only on registered occupancy, flush kills both transfers
    always_comb begin
        if_ready_o   = count < CW'(DEPTH);
        id_valid_o   = count != '0;
        push         = if_valid_i & if_ready_o & ~flush_i;
        pop          = id_valid_o & id_ready_i & ~flush_i;
        id_pc_o      = id_valid_o ? pc_mem[rd_ptr] : '0;
        id_inst_o    = id_valid_o ? inst_mem[rd_ptr] : XLEN'(32'h0000_0013);
        id_illegal_o = id_valid_o & (id_inst_o[1:0] != 2'b11);
        count_o      = count;
    end

    // Pointer and occupancy tracking; power-of-two depth lets pointers wrap naturally
    always_ff @(posedge sclk_i or posedge srst_i) begin
        if (srst_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= pop  ? rd_ptr + AW'(1) : rd_ptr;
            wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
            count  <= count + CW'(push) - CW'(pop);
        end
    end

    // Entry storage, not reset: contents are only visible while counted as valid
    always_ff @(posedge sclk_i) begin
        if (push) begin
            pc_mem[wr_ptr]   <= if_pc_i;
            inst_mem[wr_ptr] <= if_inst_i;
        end
    end

`ifdef IF_ID_PERF_CNT_EN
    // Saturating counters for decode stall cycles and flushes that discard live entries
    always_ff @(posedge sclk_i or posedge srst_i) begin
        if (srst_i) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (id_valid_o & ~id_ready_i & (stall_cnt_o != '1))
                stall_cnt_o <= stall_cnt_o + 32'd1;
            if (flush_i & (count != '0) & (flush_cnt_o != '1))
                flush_cnt_o <= flush_cnt_o + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_if_id_buffer.sv
// tb_if_id_buffer: scoreboard bench for if_id_buffer
module tb_if_id_buffer;
    localparam int DEPTH = 2;
    localparam int XLEN  = 32;

    logic sclk_i = 0, srst_i, flush_i, if_valid_i, if_ready_o, id_valid_o, id_ready_i, id_illegal_o;
    logic [XLEN-1:0] if_pc_i, if_inst_i, id_pc_o, id_inst_o;
    logic [$clog2(DEPTH):0] count_o;
`ifdef IF_ID_PERF_CNT_EN
    logic [31:0] stall_cnt_o, flush_cnt_o;
    logic [31:0] m_stall = 0, m_flush = 0;
`endif

    if_id_buffer #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .sclk_i(sclk_i), .srst_i(srst_i), .flush_i(flush_i),
        .if_valid_i(if_valid_i), .if_ready_o(if_ready_o), .if_pc_i(if_pc_i), .if_inst_i(if_inst_i),
        .id_valid_o(id_valid_o), .id_ready_i(id_ready_i), .id_pc_o(id_pc_o), .id_inst_o(id_inst_o),
        .id_illegal_o(id_illegal_o), .count_o(count_o)
`ifdef IF_ID_PERF_CNT_EN
        , .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
`endif
    );

    always #5 sclk_i = ~sclk_i;

    int checks = 0, failures = 0;
    logic [63:0] q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // one cycle: drive inputs, check outputs against model at negedge, advance model
    task automatic step(input logic fl, input logic vi, input logic [31:0] pc, input logic [31:0] inst, input logic rdy);
        logic [63:0] head;
        logic push, pop;
        int n;
        flush_i = fl; if_valid_i = vi; if_pc_i = pc; if_inst_i = inst; id_ready_i = rdy;
        @(negedge sclk_i);
        n = q.size();
        head = (n != 0) ? q[0] : {32'h0, 32'h0000_0013};
        check("count", 64'(count_o), 64'(n));
        check("id_valid", 64'(id_valid_o), 64'(n != 0));
        check("if_ready", 64'(if_ready_o), 64'(n < DEPTH));
        check("id_pc", 64'(id_pc_o), 64'(head[63:32]));
        check("id_inst", 64'(id_inst_o), 64'(head[31:0]));
        check("illegal", 64'(id_illegal_o), 64'(n != 0 && head[1:0] != 2'b11));
`ifdef IF_ID_PERF_CNT_EN
        check("stall_cnt", 64'(stall_cnt_o), 64'(m_stall));
        check("flush_cnt", 64'(flush_cnt_o), 64'(m_flush));
        if (n != 0 && !rdy) m_stall++;
        if (fl && n != 0) m_flush++;
`endif
        push = vi && n < DEPTH && !fl;
        pop  = n != 0 && rdy && !fl;
        if (fl) q.delete();
        else begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back({pc, inst});
        end
        @(posedge sclk_i);
        #1;
    endtask

    initial begin
        srst_i = 1; flush_i = 0; if_valid_i = 0; if_pc_i = 0; if_inst_i = 0; id_ready_i = 0;
        repeat (2) @(posedge sclk_i);
        #1;
        check("rst_count", 64'(count_o), 0);
        check("rst_valid", 64'(id_valid_o), 0);
        check("rst_inst", 64'(id_inst_o), 64'h13);
        srst_i = 0;
        #1;
        check("rst_ready", 64'(if_ready_o), 1);
        // streaming
        step(0, 1, 32'h0, 32'h0050_0093, 1);
        step(0, 1, 32'h4, 32'h0010_0113, 1);
        step(0, 1, 32'h8, 32'h0020_81B3, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        // back-pressure to full, third pair held by fetch
        step(0, 1, 32'h0, 32'h0050_0093, 0);
        step(0, 1, 32'h4, 32'h0010_0113, 0);
        step(0, 1, 32'h8, 32'h0020_81B3, 0);
        step(0, 1, 32'h8, 32'h0020_81B3, 1);
        step(0, 1, 32'h8, 32'h0020_81B3, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        // flush mid-stream
        step(0, 1, 32'h10, 32'h0000_0113, 0);
        step(0, 1, 32'h14, 32'h0000_0193, 0);
        step(1, 1, 32'h18, 32'h0000_0213, 1);
        step(0, 1, 32'h40, 32'h0000_0293, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        // wrap-around with simultaneous push+pop
        step(0, 1, 32'h100, 32'h1111_1113, 0);
        for (int i = 1; i < 5; i++) step(0, 1, 32'h100 + 32'(4 * i), 32'h1111_1113 + 32'(i << 8), 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
`ifdef IF_ID_PERF_CNT_EN
        step(0, 1, 32'h200, 32'h0000_0013, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 1, 32'h204, 32'h0000_0013, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
`endif
        // illegal flag, then asynchronous reset mid-cycle
        step(0, 1, 32'h300, 32'h0000_0001, 0);
        step(0, 1, 32'h304, 32'h0000_0013, 0);
        step(0, 0, 0, 0, 0);
        #2 srst_i = 1;
        #1;
        check("arst_valid", 64'(id_valid_o), 0);
        check("arst_count", 64'(count_o), 0);
        q.delete();
`ifdef IF_ID_PERF_CNT_EN
        m_stall = 0; m_flush = 0;
`endif
        @(posedge sclk_i);
        #1 srst_i = 0;
        // random traffic
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0, $urandom, $urandom, $urandom_range(0, 2) != 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
